// File: rtl/csa_mul_accum.sv
// Iterative shift-add multiplier that keeps its running product in carry-save form.
// Emits a (sum, carry) pair whose modular sum is a*b mod 2^WIDTH for the downstream final adder.
module csa_mul_accum #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [WIDTH-1:0] out_carry,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_sum_acc;
  logic [WIDTH-1:0]   r_carry_acc;
  logic [CNT_W-1:0]   r_count;

  logic [WIDTH-1:0]   w_pp;
  logic [WIDTH-1:0]   w_s;
  logic [WIDTH-1:0]   w_maj;
  logic [WIDTH-1:0]   w_c;
  logic               w_last;

  // One 3:2 compressor row per cycle; the majority MSB falls off the top when shifted.
  assign w_pp   = r_mplier[0] ? r_mcand : '0;
  assign w_s    = r_sum_acc ^ r_carry_acc ^ w_pp;
  assign w_maj  = (r_sum_acc & r_carry_acc) | (r_sum_acc & w_pp) | (r_carry_acc & w_pp);
  assign w_c    = {w_maj[WIDTH-2:0], 1'b0};
  assign w_last = (r_mplier[WIDTH-1:1] == '0) || (r_count == CNT_W'(WIDTH - 1));

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next_state = RUN;
      RUN:     if (w_last)    w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default:                w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_sum_acc   <= '0;
      r_carry_acc <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mcand     <= in_a;
            r_mplier    <= in_b;
            r_sum_acc   <= '0;
            r_carry_acc <= '0;
            r_count     <= '0;
          end
        end
        RUN: begin
          r_sum_acc   <= w_s;
          r_carry_acc <= w_c;
          r_mcand     <= {r_mcand[WIDTH-2:0], 1'b0};
          r_mplier    <= {1'b0, r_mplier[WIDTH-1:1]};
          r_count     <= r_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Handshake and result outputs come straight from registers.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_sum   = r_sum_acc;
  assign out_carry = r_carry_acc;

endmodule

// File: tb/tb_csa_mul_accum.sv
// Self-checking bench for csa_mul_accum: scoreboard of expected products and RUN-cycle counts.
module tb_csa_mul_accum;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [WIDTH-1:0] out_carry;
  logic             busy;

  typedef struct {
    logic [WIDTH-1:0] prod;
    int               runs;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   failed    = 0;

  csa_mul_accum #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_runs(input logic [WIDTH-1:0] b);
    int r;
    r = 1;
    for (int i = 0; i < WIDTH; i++) if (b[i]) r = i + 1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted, pushing the expected result when they are taken.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) begin
      tests_run++;
      failed++;
      $display("FAIL issue_timeout: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    e.prod   = a * b;
    e.runs   = exp_runs(b);
    sb.push_back(e);
    step();
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
  endtask

  // Count RUN cycles until out_valid, stall gap cycles, then hand off.
  task automatic collect(input int gap, output logic [WIDTH-1:0] s, output logic [WIDTH-1:0] c,
                         output int runs);
    int n;
    runs = 0;
    n    = 0;
    while (!out_valid && n < 200) begin
      if (busy) runs++;
      step();
      n++;
    end
    if (!out_valid) begin
      tests_run++;
      failed++;
      $display("FAIL collect_timeout: out_valid=%0b required 1", out_valid);
    end
    s = out_sum;
    c = out_carry;
    for (int i = 0; i < gap; i++) begin
      out_ready = 1'b0;
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    step();
    step();
    rst_n = 1'b1;
    tests_run++;
    if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    tests_run++;
    if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests_run++;
    if (out_sum !== '0) begin failed++; $display("FAIL reset_out_sum: got %h want 0", out_sum); end
    tests_run++;
    if (out_carry !== '0) begin failed++; $display("FAIL reset_out_carry: got %h want 0", out_carry); end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] s, c;
    int               runs;
    exp_t             e;
    out_ready = 1'b1;
    issue(32'd3, 32'd5);
    collect(0, s, c, runs);
    e = sb.pop_front();
    tests_run++;
    if (runs !== e.runs) begin failed++; $display("FAIL basic_runs: got %0d want %0d", runs, e.runs); end
    tests_run++;
    if (s + c !== e.prod) begin failed++; $display("FAIL basic_product: got %h want %h", s + c, e.prod); end
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failed++;
      $display("FAIL basic_after_handoff: in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_boundaries();
    logic [WIDTH-1:0] a_t[3] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0001};
    logic [WIDTH-1:0] b_t[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    logic [WIDTH-1:0] p_t[3] = '{32'h0000_0001, 32'h0000_0000, 32'h8000_0000};
    int               r_t[3] = '{32, 1, 32};
    logic [WIDTH-1:0] s, c;
    int               runs;
    exp_t             e;
    for (int i = 0; i < 3; i++) begin
      issue(a_t[i], b_t[i]);
      collect(1, s, c, runs);
      e = sb.pop_front();
      tests_run++;
      if (runs !== r_t[i] || runs !== e.runs) begin
        failed++;
        $display("FAIL boundary_runs[%0d]: got %0d want %0d", i, runs, r_t[i]);
      end
      tests_run++;
      if (s + c !== p_t[i] || s + c !== e.prod) begin
        failed++;
        $display("FAIL boundary_product[%0d]: got %h want %h", i, s + c, p_t[i]);
      end
      if (i == 1) begin
        tests_run++;
        if (s !== '0 || c !== '0) begin
          failed++;
          $display("FAIL zero_b_vectors: sum=%h carry=%h want 0/0", s, c);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] s0, c0, s, c;
    int               runs, n;
    exp_t             e;
    issue(32'd7, 32'd6);
    n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    s0 = out_sum;
    c0 = out_carry;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1;
        in_a     = 32'd9;
        in_b     = 32'd9;
      end else begin
        in_valid = 1'b0;
      end
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== s0 || out_carry !== c0) begin
        failed++;
        $display("FAIL stall_hold[%0d]: valid=%0b ready=%0b sum=%h carry=%h want 1/0/%h/%h",
                 i, out_valid, in_ready, out_sum, out_carry, s0, c0);
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    e = sb.pop_front();
    tests_run++;
    if (s0 + c0 !== e.prod) begin failed++; $display("FAIL stall_product: got %h want %h", s0 + c0, e.prod); end
    step();
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL stall_no_capture: busy=%0b in_ready=%0b want 0/1", busy, in_ready);
    end
    issue(32'd9, 32'd9);
    collect(0, s, c, runs);
    e = sb.pop_front();
    tests_run++;
    if (s + c !== 32'd81 || e.prod !== 32'd81) begin
      failed++;
      $display("FAIL stall_followup: got %h want %h", s + c, 32'd81);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [WIDTH-1:0] s, c;
    int               runs;
    exp_t             e;
    bit               stale;
    issue(32'hDEAD_BEEF, 32'h0000_FFFF);
    for (int i = 0; i < 7; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    void'(sb.pop_front());
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== '0 || out_carry !== '0) begin
      failed++;
      $display("FAIL midrun_reset: ready=%0b valid=%0b busy=%0b sum=%h carry=%h want 1/0/0/0/0",
               in_ready, out_valid, busy, out_sum, out_carry);
    end
    stale = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid || busy) stale = 1'b1;
      step();
    end
    tests_run++;
    if (stale) begin failed++; $display("FAIL midrun_stale: activity seen=%0b want 0", stale); end
    issue(32'd10, 32'd10);
    collect(0, s, c, runs);
    e = sb.pop_front();
    tests_run++;
    if (s + c !== 32'd100 || e.prod !== 32'd100) begin
      failed++;
      $display("FAIL midrun_followup: got %h want %h", s + c, 32'd100);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b, s, c;
    int               runs;
    exp_t             e;
    for (int k = 0; k < 1000; k++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) b = '0;
      issue(a, b);
      collect($urandom_range(0, 3), s, c, runs);
      e = sb.pop_front();
      tests_run++;
      if (s + c !== e.prod || runs !== e.runs) begin
        failed++;
        $display("FAIL random[%0d]: a=%h b=%h got %h/%0d want %h/%0d", k, a, b, s + c, runs, e.prod, e.runs);
      end
    end
    tests_run++;
    if (sb.size() !== 0) begin failed++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
